load_store_unit: RTL and testbench

Sits between the CPU datapath (ALU result, rt operand, control) and the word-organised data memory. Adds byte/halfword/word loads with sign or zero extension, and sub-word stores via read-modify-write. Stores go through a DEPTH-entry posted store buffer that drains to memory in the background. Loads use the memory read port directly and stall only on structural or address conflicts.

---
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sign/zero-extending sub-word loads and posted stores drained through a
// DEPTH-entry buffer, with read-modify-write for partial words on a word-organised memory.
module load_store_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        drained,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, MERGE, WRITE} state_e;

    state_e        state_q;
    logic [29:0]   addr_q [DEPTH];
    logic [3:0]    mask_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   merge_q;

    logic          is_store, is_load, bad_align, full, empty, pop, push;
    logic          conflict, load_go, load_stall, store_stall, port_free;
    logic [29:0]   head_addr;
    logic [3:0]    head_mask;
    logic [31:0]   head_data;
    logic [3:0]    st_mask;
    logic [31:0]   st_data;
    logic [31:0]   lane_word;
    logic [31:0]   merged;
    logic [PW-1:0] rel;
    logic [PW-1:0] idx;

    assign is_store    = cpu_write;
    assign is_load     = cpu_read & ~cpu_write;
    assign bad_align   = (cpu_size == 2'b01) ? cpu_address[0]
                       : (cpu_size[1] ? (cpu_address[1:0] != 2'b00) : 1'b0);
    assign misaligned  = (is_store | is_load) & bad_align;
    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign pop         = (state_q == WRITE);
    assign head_addr   = addr_q[rd_ptr_q];
    assign head_mask   = mask_q[rd_ptr_q];
    assign head_data   = data_q[rd_ptr_q];
    assign drained     = empty & (state_q == IDLE);

    // Any live entry (head included) holding the requested word blocks the load.
    always_comb begin
        conflict = 1'b0;
        rel      = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = PW'(i);
            rel = idx - rd_ptr_q;
            if (({1'b0, rel} < count_q) && (addr_q[idx] == cpu_address[31:2]))
                conflict = 1'b1;
        end
    end

    assign load_go     = is_load & ~bad_align & (state_q == IDLE) & ~full & ~conflict;
    assign load_stall  = is_load & ~bad_align & ~load_go;
    assign store_stall = is_store & ~bad_align & full & ~pop;
    assign stall       = load_stall | store_stall;
    assign push        = is_store & ~bad_align & ~store_stall;
    assign port_free   = ~load_go | full;

    always_comb begin
        st_mask = 4'b1111;
        st_data = cpu_wdata;
        case (cpu_size)
            2'b00: begin
                st_mask = 4'b0001 << cpu_address[1:0];
                st_data = cpu_wdata << {cpu_address[1:0], 3'b000};
            end
            2'b01: begin
                st_mask = cpu_address[1] ? 4'b1100 : 4'b0011;
                st_data = cpu_wdata << {cpu_address[1], 4'b0000};
            end
            default: ;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        for (int unsigned b = 0; b < 4; b++)
            if (head_mask[b]) merged[8*b +: 8] = head_data[8*b +: 8];
    end

    always_comb begin
        lane_word = mem_rdata >> {cpu_address[1:0], 3'b000};
        cpu_rdata = '0;
        if (load_go) begin
            case (cpu_size)
                2'b00: cpu_rdata = cpu_unsigned ? {24'd0, lane_word[7:0]}
                                                : {{24{lane_word[7]}}, lane_word[7:0]};
                2'b01: cpu_rdata = cpu_unsigned ? {16'd0, lane_word[15:0]}
                                                : {{16{lane_word[15]}}, lane_word[15:0]};
                default: cpu_rdata = mem_rdata;
            endcase
        end
    end

    // The read port serves loads while idle and the merge read otherwise.
    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        case (state_q)
            MERGE: begin
                mem_address = {head_addr, 2'b00};
                mem_read    = 1'b1;
            end
            WRITE: begin
                mem_address = {head_addr, 2'b00};
                mem_write   = 1'b1;
                mem_wdata   = (&head_mask) ? head_data : merge_q;
            end
            default: begin
                if (load_go) begin
                    mem_address = {cpu_address[31:2], 2'b00};
                    mem_read    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                mask_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= cpu_address[31:2];
                mask_q[wr_ptr_q] <= st_mask;
                data_q[wr_ptr_q] <= st_data;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            merge_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (!empty && port_free) state_q <= (&head_mask) ? WRITE : MERGE;
                MERGE: begin
                    merge_q <= merged;
                    state_q <= WRITE;
                end
                WRITE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed timing/literal cases plus randomized traffic checked
// every cycle against a program-order memory model and a queue of posted stores.
module tb_load_store_unit;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MW    = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_address, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned, cpu_read, cpu_write;
    logic        stall, misaligned, drained;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    logic [31:0] pmem [MW];
    logic [31:0] amem [MW];
    logic [31:0] cmem [MW];

    typedef struct {
        logic [29:0] w;
        logic [3:0]  m;
        logic [31:0] d;
    } st_t;
    st_t q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int streak = 0;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .stall(stall), .misaligned(misaligned), .drained(drained),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    assign mem_rdata = pmem[mem_address[7:2]];
    always @(posedge clk) if (mem_write) pmem[mem_address[7:2]] <= mem_wdata;

    function void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Build the posted entry byte by byte from the request.
    function automatic st_t mk_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        st_t s;
        int  n;
        int  lane;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        s.w = a[31:2];
        s.m = '0;
        s.d = '0;
        for (int k = 0; k < n; k++) begin
            lane = int'(a[1:0]) + k;
            s.m[lane] = 1'b1;
            s.d[8*lane +: 8] = wd[8*k +: 8];
        end
        return s;
    endfunction

    function automatic logic [31:0] apply(input logic [31:0] w, input st_t s);
        logic [31:0] r;
        r = w;
        for (int b = 0; b < 4; b++) if (s.m[b]) r[8*b +: 8] = s.d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic u);
        logic [31:0] v;
        int          n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v = '0;
        for (int k = 0; k < n; k++) v = v | (((w >> (8 * (int'(a) + k))) & 32'hFF) << (8 * k));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Per-cycle comparison against the model; model state advances for the coming edge.
    logic ld, st, mis_exp, hit, ldv;
    st_t  s_new;
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            for (int i = 0; i < MW; i++) amem[i] = cmem[i];
            streak = 0;
        end else begin
            st = cpu_write;
            ld = cpu_read && !cpu_write;
            mis_exp = (st || ld) && ((cpu_size == 2'd1 && cpu_address[0]) ||
                                     (cpu_size[1] && cpu_address[1:0] != 2'b00));
            chk("misaligned", misaligned, mis_exp);
            chk("drained", drained, q.size() == 0);
            chk("mem_addr_align", mem_address[1:0], 0);
            hit = 1'b0;
            foreach (q[i]) if (q[i].w == cpu_address[31:2]) hit = 1'b1;
            if (mis_exp) chk("misaligned_no_stall", stall, 0);
            else if (st) chk("store_stall", stall, (q.size() == DEPTH) && !mem_write);
            else if (ld) begin
                if (hit || q.size() == DEPTH) chk("load_must_stall", stall, 1);
                else if (q.size() == 0) chk("load_no_stall", stall, 0);
            end
            ldv = ld && !mis_exp && !stall;
            if (ldv) begin
                chk("load_rdata", cpu_rdata,
                    ld_model(amem[cpu_address[7:2]], cpu_address[1:0], cpu_size, cpu_unsigned));
                chk("load_mem_read", mem_read, 1);
            end
            if (mem_write) begin
                if (q.size() == 0) chk("spurious_write", mem_write, 0);
                else begin
                    chk("write_addr", mem_address, {q[0].w, 2'b00});
                    chk("write_data", mem_wdata, apply(cmem[q[0].w[5:0]], q[0]));
                    cmem[q[0].w[5:0]] = apply(cmem[q[0].w[5:0]], q[0]);
                    void'(q.pop_front());
                end
            end else if (q.size() == 0 && !ldv) begin
                chk("idle_outputs", {mem_read, mem_address[30:0]}, 0);
                chk("idle_wdata", mem_wdata, 0);
            end
            if (st && !mis_exp && !stall) begin
                s_new = mk_store(cpu_address, cpu_size, cpu_wdata);
                q.push_back(s_new);
                amem[s_new.w[5:0]] = apply(amem[s_new.w[5:0]], s_new);
            end
            streak = stall ? streak + 1 : 0;
            if (streak > 50) begin
                chk("stall_bound", streak, 50);
                streak = 0;
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                          input logic u, input logic [31:0] wd, output int stalls,
                          output logic [31:0] rdata);
        cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_size = sz;
        cpu_unsigned = u; cpu_wdata = wd;
        stalls = 0;
        @(negedge clk);
        while (stall && stalls < 60) begin
            stalls++;
            @(negedge clk);
        end
        if (stall) chk("request_timeout", stall, 0);
        rdata = cpu_rdata;
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        @(negedge clk);
        while (!drained && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain_bound", drained, 1);
        @(posedge clk); #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    int          ns;
    int          stl [8];
    int          r;
    logic [31:0] rd;
    logic        hold;

    initial begin
        for (int i = 0; i < MW; i++) pmem[i] = 32'h0;
        pmem[0]  = 32'h1122_3344;
        pmem[1]  = 32'h5566_7788;
        pmem[16] = 32'hCAFE_F00D;
        for (int i = 0; i < MW; i++) begin
            amem[i] = pmem[i];
            cmem[i] = pmem[i];
        end
        reset = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_wdata = '0;
        cpu_size = 2'd0; cpu_unsigned = 1'b0;
        @(negedge clk);
        chk("reset_drained", drained, 1);
        chk("reset_stall", stall, 0);
        chk("reset_mem_write", mem_write, 0);
        chk("reset_mem_address", mem_address, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Full-word store commits two edges after acceptance.
        do_req(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, ns, rd);
        chk("sw_no_stall", ns, 0);
        tick();
        chk("sw_not_yet", pmem[4], 32'h0);
        tick();
        chk("sw_commit_n2", pmem[4], 32'hDEAD_BEEF);
        wait_drained();

        // Partial store goes through MERGE and commits three edges after acceptance.
        do_req(1'b0, 1'b1, 32'h2, 2'd0, 1'b0, 32'h0000_00AA, ns, rd);
        tick(); tick();
        chk("sb_not_yet", pmem[0], 32'h1122_3344);
        tick();
        chk("sb_commit_n3", pmem[0], 32'h11AA_3344);
        do_req(1'b1, 1'b0, 32'h2, 2'd0, 1'b0, '0, ns, rd);
        chk("lb_value", rd, 32'hFFFF_FFAA);
        chk("lb_no_stall", ns, 0);
        do_req(1'b1, 1'b0, 32'h2, 2'd0, 1'b1, '0, ns, rd);
        chk("lbu_value", rd, 32'h0000_00AA);

        do_req(1'b0, 1'b1, 32'h6, 2'd1, 1'b0, 32'h0000_8001, ns, rd);
        wait_drained();
        chk("sh_commit", pmem[1], 32'h8001_7788);
        do_req(1'b1, 1'b0, 32'h6, 2'd1, 1'b0, '0, ns, rd);
        chk("lh_value", rd, 32'hFFFF_8001);
        do_req(1'b1, 1'b0, 32'h6, 2'd1, 1'b1, '0, ns, rd);
        chk("lhu_value", rd, 32'h0000_8001);

        // Back-to-back word stores outpace the drain; the buffer fills on the 8th.
        for (int i = 0; i < 8; i++) do_req(1'b0, 1'b1, 32'h80 + 32'(4 * i), 2'd2, 1'b0,
                                           32'hC0DE_0000 + 32'(i), stl[i], rd);
        for (int i = 0; i < 7; i++) chk("burst_no_stall", stl[i], 0);
        chk("burst_full_stall", stl[7], 1);
        wait_drained();
        for (int i = 0; i < 8; i++) chk("burst_landed", pmem[32 + i], 32'hC0DE_0000 + 32'(i));

        // Load of a word still in the buffer waits for its commit.
        do_req(1'b0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h1234_5678, ns, rd);
        do_req(1'b1, 1'b0, 32'h20, 2'd2, 1'b0, '0, ns, rd);
        chk("raw_stall_cycles", ns, 2);
        chk("raw_value", rd, 32'h1234_5678);
        wait_drained();
        do_req(1'b1, 1'b0, 32'h40, 2'd2, 1'b0, '0, ns, rd);
        chk("idle_load_no_stall", ns, 0);
        chk("idle_load_value", rd, 32'hCAFE_F00D);

        // Misaligned requests are dropped without stalling.
        cpu_read = 1'b1; cpu_address = 32'h3; cpu_size = 2'd1;
        @(negedge clk);
        chk("lh3_misaligned", misaligned, 1);
        chk("lh3_stall", stall, 0);
        tick();
        cpu_read = 1'b0; cpu_write = 1'b1; cpu_address = 32'h2; cpu_size = 2'd2;
        cpu_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("sw2_misaligned", misaligned, 1);
        chk("sw2_stall", stall, 0);
        tick();
        cpu_write = 1'b0;
        tick(); tick(); tick();
        chk("misaligned_mem_unchanged", pmem[0], 32'h11AA_3344);
        chk("misaligned_drained", drained, 1);

        // Reset while a partial store is merging discards it.
        do_req(1'b0, 1'b1, 32'h1, 2'd0, 1'b0, 32'h0000_0055, ns, rd);
        tick();
        chk("in_merge_read", mem_read, 1);
        reset = 1'b1;
        #1;
        chk("reset_mid_drained", drained, 1);
        chk("reset_mid_no_write", mem_write, 0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick(); tick();
        chk("reset_mem_unchanged", pmem[0], 32'h11AA_3344);
        chk("reset_then_drained", drained, 1);

        // Random traffic on a small address window to provoke conflicts and full buffers.
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                r = int'($urandom_range(0, 9));
                cpu_read     = (r < 4) || (r == 8);
                cpu_write    = (r >= 4 && r < 8) || (r == 8);
                cpu_size     = 2'($urandom_range(0, 3));
                cpu_unsigned = 1'($urandom_range(0, 1));
                cpu_wdata    = $urandom;
                cpu_address  = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 7) != 0) begin
                    if (cpu_size == 2'd1) cpu_address[0] = 1'b0;
                    else if (cpu_size[1]) cpu_address[1:0] = 2'b00;
                end
            end
            @(negedge clk);
            hold = stall;
            tick();
        end
        cpu_read = 1'b0; cpu_write = 1'b0;
        wait_drained();
        for (int i = 0; i < MW; i++) chk("final_memory", pmem[i], amem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
